quiz_round_ctrl: RTL and testbench
==================================

# quiz_round_ctrl

Sequencing controller for the two-player quiz game. It steps the question index that drives the question/answer lookup and display, and arbitrates the left and right joysticks so that exactly one buzz is judged at a time. It owns both score counters and detects game over, replacing the free-running trigger-driven counters with one clocked round state machine.

## Interface
- NUM_Q, default 8: number of questions; qIndex wraps NUM_Q-1 → 0.
- WIN_SCORE, default 5: score that ends the game, 1..7.
- TIMEOUT, default 1000: WAIT cycles before the question expires unanswered.
- RESULT_HOLD, default 500: cycles the result is held before the next question.
- clk  in  1  system clock.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- joyInL  in  4  left joystick, active-low one-hot; 1110→1, 1101→2, 1011→3, 0111→4.
- joyInR  in  4  right joystick, same coding.
- ans  in  3  correct answer (1..4) for the current qIndex, from the question table.
- qIndex  out  3  current question number.
- scoreLeft  out  3  left score, 0..WIN_SCORE.
- scoreRight  out  3  right score, 0..WIN_SCORE.
- resultValid  out  1  high during SHOW.
- resultCode  out  2  00 timeout, 01 left correct, 10 right correct, 11 wrong.
- gameOver  out  1  high in OVER.
- winnerL / winnerR  out  1  the player who reached WIN_SCORE.

## Operation
- Each joystick is registered once (cur) and again (prev).
- Valid press: cur is one of the four codes and prev = 1111. Any other cur value is ignored.
- States:
  - ASK: lasts 1 cycle. Clears lockouts and the timeout counter, then goes to WAIT.
  - WAIT: on a valid press from a non-locked player, capture that player and code, then go to JUDGE. When the timeout counter reaches TIMEOUT-1, set resultCode=00 and go to SHOW.
  - JUDGE: lasts 1 cycle. If code = ans, increment that player's score and set resultCode 01 or 10. Otherwise set resultCode 11. Then go to SHOW.
  - SHOW: hold RESULT_HOLD cycles. Then qIndex advances with wrap, and the next state is ASK. If either score equals WIN_SCORE, the next state is OVER instead and qIndex does not advance.
  - OVER: terminal until rst. Scores freeze and presses are ignored.
- Simultaneous valid presses in the same cycle: a priority token decides the winner.
  - Token is left after reset.
  - Token flips to the other player each time it resolves a tie.
  - The loser's press is discarded.
- Presses in ASK, JUDGE, SHOW or OVER are discarded. A button still held when WAIT begins does not count until it is released and pressed again.
- Scores saturate at WIN_SCORE.

## Timing
- Reset values: qIndex=0, scores=0, resultValid=0, resultCode=00, gameOver=0, winnerL=winnerR=0, token=left, state=ASK.
- Latency for a press driven before edge k (captured in cur at edge k):
  - JUDGE entered at edge k+1.
  - Score and resultValid update at edge k+2.
- SHOW lasts exactly RESULT_HOLD cycles.
- The qIndex change and ASK entry occur on the same edge.
- Timeout: WAIT lasts exactly TIMEOUT cycles when no press is accepted.
- rst mid-round: on the next edge all state returns to reset values and qIndex=0.
- gameOver and winner outputs assert on the edge that leaves SHOW.

## Configuration
- WRONG_PENALTY_EN defined:
  - A wrong answer locks out the answering player, clears resultValid, and returns to WAIT without resetting the timeout counter.
  - The other player may still answer.
  - If both players are locked out, go to SHOW with resultCode=11.
  - Presses from a locked player are ignored.
- WRONG_PENALTY_EN undefined: a wrong answer goes straight to SHOW with resultCode=11 and no lockout logic.

## Test plan
- Reset, ans=2, left presses 1101 → at k+2: scoreLeft=1, resultCode=01; after RESULT_HOLD, qIndex=1.
- Both sticks press 1110 in the same cycle, ans=1, twice in two rounds → first round right score 0 and scoreLeft=1; second round scoreRight=1 (token flipped).
- No press for TIMEOUT cycles → resultCode=00, scores unchanged, qIndex advances.
- ans=3, right presses 1110:
  - Without macro → resultCode=11.
  - With macro → right locked out; left presses 1011 → scoreLeft=1.
- Left wins WIN_SCORE=5 rounds → gameOver=1 and winnerL=1 after SHOW; further presses leave scoreLeft=5; qIndex wraps 7→0 in an 8+ round game.
- Assert rst during SHOW with scoreLeft=3 → next edge: all outputs at reset values, state ASK.

Source files
------------

// File: rtl/quiz_round_if.sv
// Joystick/answer inputs and round status outputs of the quiz round controller.
// The controller takes the slave view; the game top (or bench) takes the master view.
interface quiz_round_if;
  logic [3:0] joyInL;
  logic [3:0] joyInR;
  logic [2:0] ans;
  logic [2:0] qIndex;
  logic [2:0] scoreLeft;
  logic [2:0] scoreRight;
  logic       resultValid;
  logic [1:0] resultCode;
  logic       gameOver;
  logic       winnerL;
  logic       winnerR;

  modport master (
    output joyInL, joyInR, ans,
    input  qIndex, scoreLeft, scoreRight, resultValid, resultCode,
           gameOver, winnerL, winnerR
  );

  modport slave (
    input  joyInL, joyInR, ans,
    output qIndex, scoreLeft, scoreRight, resultValid, resultCode,
           gameOver, winnerL, winnerR
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the two-player quiz: buzz arbitration, judging, scores, game over.
// Optional macro WRONG_PENALTY_EN: a wrong answer locks that player out and reopens the question.
module quiz_round_ctrl #(
  parameter int NUM_Q       = 8,
  parameter int WIN_SCORE   = 5,
  parameter int TIMEOUT     = 1000,
  parameter int RESULT_HOLD = 500
) (
  input  logic         clk,
  input  logic         rst,
  quiz_round_if.slave  bus
);

  typedef enum logic [2:0] {ASK, WAIT, JUDGE, SHOW, OVER} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(RESULT_HOLD + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HLAST = HW'(RESULT_HOLD - 1);
  localparam logic [2:0]    QLAST = 3'(NUM_Q - 1);
  localparam logic [2:0]    WIN   = 3'(WIN_SCORE);

  function automatic logic [2:0] decode(input logic [3:0] joy);
    case (joy)
      4'b1110: decode = 3'd1;
      4'b1101: decode = 3'd2;
      4'b1011: decode = 3'd3;
      4'b0111: decode = 3'd4;
      default: decode = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    sat_inc = (s >= WIN) ? WIN : s + 3'd1;
  endfunction

  state_t        state;
  logic [3:0]    joy_l_p0, joy_l_p1, joy_r_p0, joy_r_p1;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;
  logic          token_r;
  logic          sel_r;
  logic [2:0]    code_r;
  logic [2:0]    dec_l, dec_r;
  logic          press_l, press_r;

  assign dec_l = decode(joy_l_p0);
  assign dec_r = decode(joy_r_p0);

`ifdef WRONG_PENALTY_EN
  logic lock_l, lock_r;
  assign press_l = (dec_l != 3'd0) && (joy_l_p1 == 4'hF) && !lock_l;
  assign press_r = (dec_r != 3'd0) && (joy_r_p1 == 4'hF) && !lock_r;
`else
  assign press_l = (dec_l != 3'd0) && (joy_l_p1 == 4'hF);
  assign press_r = (dec_r != 3'd0) && (joy_r_p1 == 4'hF);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ASK;
      joy_l_p0        <= 4'hF;
      joy_l_p1        <= 4'hF;
      joy_r_p0        <= 4'hF;
      joy_r_p1        <= 4'hF;
      tmo_cnt         <= '0;
      hold_cnt        <= '0;
      token_r         <= 1'b0;
      sel_r           <= 1'b0;
      code_r          <= 3'd0;
      bus.qIndex      <= 3'd0;
      bus.scoreLeft   <= 3'd0;
      bus.scoreRight  <= 3'd0;
      bus.resultValid <= 1'b0;
      bus.resultCode  <= 2'b00;
      bus.gameOver    <= 1'b0;
      bus.winnerL     <= 1'b0;
      bus.winnerR     <= 1'b0;
`ifdef WRONG_PENALTY_EN
      lock_l          <= 1'b0;
      lock_r          <= 1'b0;
`endif
    end else begin
      // p0 = current joystick sample, p1 = previous; a press is a fresh edge from all-released
      joy_l_p0 <= bus.joyInL;
      joy_l_p1 <= joy_l_p0;
      joy_r_p0 <= bus.joyInR;
      joy_r_p1 <= joy_r_p0;

      unique case (state)
        ASK: begin
          tmo_cnt <= '0;
`ifdef WRONG_PENALTY_EN
          lock_l  <= 1'b0;
          lock_r  <= 1'b0;
`endif
          state   <= WAIT;
        end
        WAIT: begin
          if (press_l || press_r) begin
            if (press_l && press_r) begin
              sel_r   <= token_r;
              code_r  <= token_r ? dec_r : dec_l;
              token_r <= ~token_r;
            end else begin
              sel_r   <= press_r;
              code_r  <= press_r ? dec_r : dec_l;
            end
            state <= JUDGE;
          end else if (tmo_cnt == TLAST) begin
            bus.resultCode  <= 2'b00;
            bus.resultValid <= 1'b1;
            hold_cnt        <= '0;
            state           <= SHOW;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        JUDGE: begin
          if (code_r == bus.ans) begin
            if (sel_r) bus.scoreRight <= sat_inc(bus.scoreRight);
            else       bus.scoreLeft  <= sat_inc(bus.scoreLeft);
            bus.resultCode  <= sel_r ? 2'b10 : 2'b01;
            bus.resultValid <= 1'b1;
            hold_cnt        <= '0;
            state           <= SHOW;
          end else begin
`ifdef WRONG_PENALTY_EN
            // the timeout counter keeps running across the reopened question
            if (sel_r) lock_r <= 1'b1;
            else       lock_l <= 1'b1;
            if (sel_r ? lock_l : lock_r) begin
              bus.resultCode  <= 2'b11;
              bus.resultValid <= 1'b1;
              hold_cnt        <= '0;
              state           <= SHOW;
            end else begin
              bus.resultValid <= 1'b0;
              state           <= WAIT;
            end
`else
            bus.resultCode  <= 2'b11;
            bus.resultValid <= 1'b1;
            hold_cnt        <= '0;
            state           <= SHOW;
`endif
          end
        end
        SHOW: begin
          if (hold_cnt == HLAST) begin
            bus.resultValid <= 1'b0;
            if (bus.scoreLeft == WIN || bus.scoreRight == WIN) begin
              bus.gameOver <= 1'b1;
              bus.winnerL  <= (bus.scoreLeft == WIN);
              bus.winnerR  <= (bus.scoreRight == WIN);
              state        <= OVER;
            end else begin
              bus.qIndex <= (bus.qIndex == QLAST) ? 3'd0 : bus.qIndex + 3'd1;
              state      <= ASK;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: state <= ASK;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl: a round-level model checked every cycle,
// plus literal expectations at the key points of each scripted round.
module tb_quiz_round_ctrl;
  localparam int NUM_Q = 8;
  localparam int WIN   = 5;
  localparam int TMO   = 20;
  localparam int HOLD  = 10;

  localparam int M_ASK = 0, M_WAIT = 1, M_JUDGE = 2, M_SHOW = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic rst;
  quiz_round_if bus();

  quiz_round_ctrl #(
    .NUM_Q(NUM_Q), .WIN_SCORE(WIN), .TIMEOUT(TMO), .RESULT_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- round-level model ----------------
  int         mode, wc, sc, mcode;
  int         m_q, m_sl, m_sr;
  logic [1:0] m_rc;
  bit         m_rv, m_go, m_wl, m_wr, m_tok, lk_l, lk_r, who, pl, pr;
  bit         m_init = 1'b0;
  logic [3:0] ml_cur, ml_prev, mr_cur, mr_prev;

  function automatic int code_of(input logic [3:0] v);
    case (v)
      4'b1110: return 1;
      4'b1101: return 2;
      4'b1011: return 3;
      4'b0111: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic m_show(input logic [1:0] rc);
    m_rc = rc; m_rv = 1'b1; sc = 0; mode = M_SHOW;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mode = M_ASK; m_q = 0; m_sl = 0; m_sr = 0; m_rc = 2'd0;
      m_rv = 0; m_go = 0; m_wl = 0; m_wr = 0; m_tok = 0; lk_l = 0; lk_r = 0;
      wc = 0; sc = 0; mcode = 0; who = 0;
      ml_cur = 4'hF; ml_prev = 4'hF; mr_cur = 4'hF; mr_prev = 4'hF;
      m_init = 1'b1;
    end else begin
      pl = (code_of(ml_cur) != 0) && (ml_prev == 4'hF) && !lk_l;
      pr = (code_of(mr_cur) != 0) && (mr_prev == 4'hF) && !lk_r;
      case (mode)
        M_ASK: begin mode = M_WAIT; wc = 0; lk_l = 0; lk_r = 0; end
        M_WAIT: begin
          if (pl || pr) begin
            if (pl && pr) begin who = m_tok; m_tok = !m_tok; end
            else who = pr;
            mcode = who ? code_of(mr_cur) : code_of(ml_cur);
            mode  = M_JUDGE;
          end else begin
            wc++;
            if (wc == TMO) m_show(2'd0);
          end
        end
        M_JUDGE: begin
          if (mcode == int'(bus.ans)) begin
            if (who) m_sr = (m_sr < WIN) ? m_sr + 1 : WIN;
            else     m_sl = (m_sl < WIN) ? m_sl + 1 : WIN;
            m_show(who ? 2'd2 : 2'd1);
          end else begin
`ifdef WRONG_PENALTY_EN
            if (who) lk_r = 1; else lk_l = 1;
            if (lk_l && lk_r) m_show(2'd3);
            else begin m_rv = 0; mode = M_WAIT; end
`else
            m_show(2'd3);
`endif
          end
        end
        M_SHOW: begin
          sc++;
          if (sc == HOLD) begin
            m_rv = 0;
            if (m_sl == WIN || m_sr == WIN) begin
              m_go = 1; m_wl = (m_sl == WIN); m_wr = (m_sr == WIN); mode = M_OVER;
            end else begin
              m_q = (m_q + 1) % NUM_Q; mode = M_ASK;
            end
          end
        end
        default: ;
      endcase
      ml_prev = ml_cur; ml_cur = bus.joyInL;
      mr_prev = mr_cur; mr_cur = bus.joyInR;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_qIndex",      32'(bus.qIndex),      m_q);
      chk("cyc_scoreLeft",   32'(bus.scoreLeft),   m_sl);
      chk("cyc_scoreRight",  32'(bus.scoreRight),  m_sr);
      chk("cyc_resultValid", 32'(bus.resultValid), 32'(m_rv));
      chk("cyc_resultCode",  32'(bus.resultCode),  32'(m_rc));
      chk("cyc_gameOver",    32'(bus.gameOver),    32'(m_go));
      chk("cyc_winnerL",     32'(bus.winnerL),     32'(m_wl));
      chk("cyc_winnerR",     32'(bus.winnerR),     32'(m_wr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_mode(input int m, input int budget);
    int n = 0;
    while (mode != m && n < budget) begin tick(); n++; end
    checks++;
    if (mode != m) begin
      failures++;
      $display("FAIL wait_mode: got mode %0d, want %0d after %0d cycles", mode, m, budget);
    end
  endtask

  // press at the first WAIT cycle; returns two edges after the press reaches cur
  task automatic round(input logic [2:0] a, input logic [3:0] jl, input logic [3:0] jr);
    bus.ans = a;
    wait_mode(M_WAIT, 2 * HOLD + TMO + 10);
    bus.joyInL = jl; bus.joyInR = jr;
    tick();
    bus.joyInL = 4'hF; bus.joyInR = 4'hF;
    tick();
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_qIndex"},  32'(bus.qIndex), 0);
    chk({tag, "_scoreL"},  32'(bus.scoreLeft), 0);
    chk({tag, "_scoreR"},  32'(bus.scoreRight), 0);
    chk({tag, "_rv"},      32'(bus.resultValid), 0);
    chk({tag, "_rc"},      32'(bus.resultCode), 0);
    chk({tag, "_over"},    32'(bus.gameOver), 0);
    chk({tag, "_winL"},    32'(bus.winnerL), 0);
    chk({tag, "_winR"},    32'(bus.winnerR), 0);
  endtask

  initial begin
    rst = 1'b1; bus.joyInL = 4'hF; bus.joyInR = 4'hF; bus.ans = 3'd1;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // round 1: ans=2, left 1101; score at k+2, qIndex advances after HOLD cycles
    bus.ans = 3'd2;
    wait_mode(M_WAIT, 5);
    bus.joyInL = 4'b1101;
    tick(); bus.joyInL = 4'hF;
    tick();
    chk("r1_k1_rv",     32'(bus.resultValid), 0);
    chk("r1_k1_scoreL", 32'(bus.scoreLeft), 0);
    tick();
    chk("r1_k2_scoreL", 32'(bus.scoreLeft), 1);
    chk("r1_k2_rc",     32'(bus.resultCode), 1);
    chk("r1_k2_rv",     32'(bus.resultValid), 1);
    repeat (HOLD - 1) tick();
    chk("r1_hold_q",    32'(bus.qIndex), 0);
    chk("r1_hold_rv",   32'(bus.resultValid), 1);
    tick();
    chk("r1_after_q",   32'(bus.qIndex), 1);
    chk("r1_after_rv",  32'(bus.resultValid), 0);

    // rounds 2/3: simultaneous 1110 with ans=1; token starts left, then flips
    round(3'd1, 4'b1110, 4'b1110);
    chk("r2_scoreL", 32'(bus.scoreLeft), 2);
    chk("r2_scoreR", 32'(bus.scoreRight), 0);
    chk("r2_rc",     32'(bus.resultCode), 1);
    round(3'd1, 4'b1110, 4'b1110);
    chk("r3_scoreL", 32'(bus.scoreLeft), 2);
    chk("r3_scoreR", 32'(bus.scoreRight), 1);
    chk("r3_rc",     32'(bus.resultCode), 2);

    // round 4: nobody presses
    round(3'd1, 4'hF, 4'hF);
    wait_mode(M_SHOW, TMO + 5);
    chk("r4_tmo_rc",     32'(bus.resultCode), 0);
    chk("r4_tmo_rv",     32'(bus.resultValid), 1);
    chk("r4_tmo_scoreL", 32'(bus.scoreLeft), 2);
    chk("r4_tmo_scoreR", 32'(bus.scoreRight), 1);

    // round 5: ans=3, right answers 1 (wrong)
    round(3'd3, 4'hF, 4'b1110);
`ifdef WRONG_PENALTY_EN
    chk("r5_lock_rv", 32'(bus.resultValid), 0);
    bus.joyInL = 4'b1011;
    tick(); bus.joyInL = 4'hF;
    tick(); tick();
    chk("r5_left_scoreL", 32'(bus.scoreLeft), 3);
    chk("r5_left_rc",     32'(bus.resultCode), 1);
`else
    chk("r5_wrong_rc",     32'(bus.resultCode), 3);
    chk("r5_wrong_rv",     32'(bus.resultValid), 1);
    chk("r5_wrong_scoreR", 32'(bus.scoreRight), 1);
`endif

    // rounds 6..8 time out; qIndex goes 5,6,7 then wraps to 0
    for (int i = 0; i < 3; i++) begin
      round(3'd1, 4'hF, 4'hF);
      wait_mode(M_SHOW, TMO + 5);
      chk("tmo_q", 32'(bus.qIndex), 5 + i);
    end
    wait_mode(M_ASK, HOLD + 5);
    chk("q_wrap", 32'(bus.qIndex), 0);

    // left wins out
    for (int g = 0; g < 8 && m_sl < WIN; g++) round(3'd4, 4'b0111, 4'hF);
    wait_mode(M_OVER, HOLD + 5);
    chk("over_go",     32'(bus.gameOver), 1);
    chk("over_winL",   32'(bus.winnerL), 1);
    chk("over_winR",   32'(bus.winnerR), 0);
    chk("over_scoreL", 32'(bus.scoreLeft), 5);
    bus.joyInL = 4'b0111;
    tick(); bus.joyInL = 4'hF;
    repeat (5) tick();
    chk("over_frozen_scoreL", 32'(bus.scoreLeft), 5);
    chk("over_frozen_go",     32'(bus.gameOver), 1);

    // fresh game, reset while showing the third left point
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst2");
    for (int g = 0; g < 3; g++) round(3'd4, 4'b0111, 4'hF);
    chk("pre_rst_scoreL", 32'(bus.scoreLeft), 3);
    chk("pre_rst_rv",     32'(bus.resultValid), 1);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("midshow_rst");
    round(3'd2, 4'b1101, 4'hF);
    chk("post_rst_scoreL", 32'(bus.scoreLeft), 1);
    chk("post_rst_rc",     32'(bus.resultCode), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
